// File: rtl/button_pkg.sv
// Shared types and helpers for the button input path.
// The tick conversion is also used by the debouncer threshold computation.
package button_pkg;

  // Classifier FSM states.
  typedef enum logic [1:0] {
    WAIT_RELEASE = 2'd0,
    IDLE         = 2'd1,
    PRESSED      = 2'd2,
    LONG_HOLD    = 2'd3
  } state_e;

  // Converts a duration in milliseconds to clock ticks. The product is formed
  // in 64 bits because 100 MHz * 1000 ms does not fit in 32 bits.
  function automatic longint unsigned ms_to_ticks(input longint unsigned freq,
                                                  input longint unsigned ms);
    return (freq * ms) / 64'd1000;
  endfunction

  // Larger of two tick counts; sizes a counter shared by two thresholds.
  function automatic longint unsigned max_ticks(input longint unsigned a,
                                                input longint unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event.sv
// Turns a debounced button level into single-cycle PRESS / SHORT / LONG /
// REPEAT pulses plus a HELD level. All outputs come straight from flops.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// WAIT_RELEASE | after reset; waits for BTN=0 so a held button is not a press
// IDLE         | released, waiting for a press
// PRESSED      | held, counting towards LONG_TICKS
// LONG_HOLD    | long press reported, emitting REPEAT every REPEAT_TICKS
module button_event
  import button_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ    = 100_000_000,
  parameter int unsigned LONG_PRESS_MS = 1000,
  parameter int unsigned REPEAT_MS     = 200
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN,
  output logic PRESS,
  output logic SHORT,
  output logic LONG,
  output logic REPEAT,
  output logic HELD
);

  localparam longint unsigned LONG_TICKS   = ms_to_ticks(64'(CLOCK_FREQ), 64'(LONG_PRESS_MS));
  localparam longint unsigned REPEAT_TICKS = ms_to_ticks(64'(CLOCK_FREQ), 64'(REPEAT_MS));
  localparam longint unsigned CNT_MAX      = max_ticks(LONG_TICKS, REPEAT_TICKS);
  localparam int              CNT_W        = $clog2(CNT_MAX);

  // Both thresholds are at least 2, so CNT_W >= 1 and TICKS-1 fits in CNT_W bits.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 64'd1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 64'd1);

  // A threshold of 0 or 1 tick would make LONG/REPEAT collide with PRESS.
  if (LONG_TICKS < 2 || REPEAT_TICKS < 2) begin : g_bad_ticks
    $error("button_event: LONG_TICKS and REPEAT_TICKS must both be >= 2");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_d, short_d, long_d, repeat_d, held_d;

  // State, shared hold counter and registered event outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= WAIT_RELEASE;
      cnt_q   <= '0;
      PRESS   <= 1'b0;
      SHORT   <= 1'b0;
      LONG    <= 1'b0;
      REPEAT  <= 1'b0;
      HELD    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      PRESS   <= press_d;
      SHORT   <= short_d;
      LONG    <= long_d;
      REPEAT  <= repeat_d;
      HELD    <= held_d;
    end
  end

  // Next state, counter and event decode; release is tested before thresholds.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    short_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;

    case (state_q)
      WAIT_RELEASE: begin
        if (!BTN) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (BTN) begin
          state_d = PRESSED;
          press_d = 1'b1;
        end
      end

      PRESSED: begin
        if (!BTN) begin
          state_d = IDLE;
          short_d = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG_HOLD;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      LONG_HOLD: begin
        if (!BTN) begin
          state_d = IDLE;
        end else if (cnt_q == REPEAT_LAST) begin
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = WAIT_RELEASE;
      end
    endcase

    held_d = (state_d == PRESSED) || (state_d == LONG_HOLD);
  end

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with LONG_TICKS=10, REPEAT_TICKS=4.
// Expected output vectors are {PRESS, SHORT, LONG, REPEAT, HELD}.
module tb_button_event;

  logic CLK;
  logic RST_N;
  logic BTN;
  logic PRESS, SHORT, LONG, REPEAT, HELD;

  int passed = 0;
  int total  = 0;

  button_event #(
    .CLOCK_FREQ   (1000),
    .LONG_PRESS_MS(10),
    .REPEAT_MS    (4)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .BTN   (BTN),
    .PRESS (PRESS),
    .SHORT (SHORT),
    .LONG  (LONG),
    .REPEAT(REPEAT),
    .HELD  (HELD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hard stop if the directed sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Compare all outputs and confirm no two event pulses overlap.
  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    logic       ok1h;
    obs  = {PRESS, SHORT, LONG, REPEAT, HELD};
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    ok1h = ($countones({PRESS, SHORT, LONG, REPEAT}) <= 1);
    total++;
    assert (ok1h === 1'b1) passed++;
    else $error("FAIL %s_overlap observed=%b expected=at_most_one_event", tag, obs[4:1]);
  endtask

  // Hold BTN for n sampled edges from IDLE, then release; check every cycle.
  task automatic run_hold(input int n);
    logic e_press, e_short, e_long, e_rep, e_held;
    BTN = 1'b1;
    for (int i = 1; i <= n + 2; i++) begin
      tick();
      e_press = (i == 1);
      e_held  = (i <= n);
      e_long  = (i == 11) && (n >= 11);
      e_short = (i == n + 1) && (n <= 10);
      e_rep   = (i >= 15) && (((i - 11) % 4) == 0) && (i <= n);
      chk($sformatf("hold%0d_c%0d", n, i), {e_press, e_short, e_long, e_rep, e_held});
      if (i == n) BTN = 1'b0;
    end
  endtask

  initial begin
    RST_N = 1'b1;
    BTN   = 1'b0;
    #3 RST_N = 1'b0;
    #1 chk("reset_async", 5'b00000);
    tick();
    tick();
    chk("reset_held", 5'b00000);
    RST_N = 1'b1;
    tick();
    chk("reset_release", 5'b00000);
    tick();

    // Short click, long hold with repeats, and release around the thresholds.
    run_hold(3);
    tick();
    run_hold(25);
    tick();
    run_hold(10);
    tick();
    run_hold(11);
    tick();
    run_hold(14);
    tick();

    // Button held through reset release must not produce a PRESS.
    BTN   = 1'b1;
    RST_N = 1'b0;
    tick();
    chk("btn_in_reset", 5'b00000);
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("wait_release_c%0d", i), 5'b00000);
    end
    BTN = 1'b0;
    tick();
    chk("wait_release_low", 5'b00000);
    BTN = 1'b1;
    tick();
    chk("repress_after_wait", 5'b10001);
    BTN = 1'b0;
    tick();
    chk("short_after_wait", 5'b01000);
    tick();

    // Reset asserted in the middle of a REPEAT cycle.
    BTN = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 11) chk("rst_pre_long", 5'b00101);
    end
    chk("rst_pre_repeat", 5'b00011);
    #2 RST_N = 1'b0;
    #1 chk("rst_mid_repeat", 5'b00000);
    tick();
    chk("rst_mid_hold", 5'b00000);
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_still_held_c%0d", i), 5'b00000);
    end
    BTN = 1'b0;
    tick();
    chk("rst_released", 5'b00000);
    BTN = 1'b1;
    tick();
    chk("rst_repress", 5'b10001);
    BTN = 1'b0;
    tick();
    chk("rst_repress_short", 5'b01000);
    tick();
    chk("rst_repress_idle", 5'b00000);

    // Fast 1,0,1,0 pattern: PRESS, SHORT, PRESS, SHORT on consecutive cycles.
    BTN = 1'b1;
    tick();
    chk("fast_press1", 5'b10001);
    BTN = 1'b0;
    tick();
    chk("fast_short1", 5'b01000);
    BTN = 1'b1;
    tick();
    chk("fast_press2", 5'b10001);
    BTN = 1'b0;
    tick();
    chk("fast_short2", 5'b01000);
    tick();
    chk("fast_idle", 5'b00000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
